// File: rtl/mips_main_control.sv
// Multicycle MIPS main control FSM. It decodes the IR opcode and steps the datapath
// through fetch, decode, execute, memory and writeback. The outputs are Moore outputs
// decoded from the state. While reset is low, every enable output is forced to 0.
module mips_main_control #(
  parameter bit ENABLE_BNE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       Branch,
  output logic       BranchNE,
  output logic       PCWrite,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpBne  = 6'b000101;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StAddiExec = 4'd9,
    StAddiWb   = 4'd10,
    StJump     = 4'd11
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] op_q;
  logic       illegal_q, dec_illegal;

  // Raw enables, gated with reset at the ports
  logic pc_write_s, ir_write_s, mem_write_s, reg_write_s, branch_s, branch_ne_s, done_s;

  // Next-state logic; an unsupported opcode in DECODE goes back to FETCH and flags illegal
  always_comb begin
    state_d     = StFetch;
    dec_illegal = 1'b0;
    case (state_q)
      StFetch:    state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpR:        state_d = StExecute;
          OpBeq:      state_d = StBranch;
          OpBne: begin
            if (ENABLE_BNE) state_d = StBranch;
            else            dec_illegal = 1'b1;
          end
          OpAddi:     state_d = StAddiExec;
          OpJ:        state_d = StJump;
          default:    dec_illegal = 1'b1;
        endcase
      end
      StMemAdr:   state_d = (op_q == OpLw) ? StMemRead : StMemWrite;
      StMemRead:  state_d = StMemWb;
      StExecute:  state_d = StAluWb;
      StAddiExec: state_d = StAddiWb;
      // Terminal states and unused codes 12-15 all return to FETCH
      default:    state_d = StFetch;
    endcase
  end

  // State, latched opcode and registered illegal pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StFetch;
      op_q      <= 6'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= dec_illegal;
      if (state_q == StDecode) op_q <= opcode;
    end
  end

  // Moore output decode; anything not set for a state stays 0
  always_comb begin
    IorD        = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSrc       = 2'b00;
    pc_write_s  = 1'b0;
    ir_write_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    branch_s    = 1'b0;
    branch_ne_s = 1'b0;
    done_s      = 1'b0;
    case (state_q)
      StFetch: begin
        ALUSrcB    = 2'b01;
        ir_write_s = 1'b1;
        pc_write_s = 1'b1;
      end
      StDecode:   ALUSrcB = 2'b11;
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StMemRead:  IorD = 1'b1;
      StMemWb: begin
        MemtoReg    = 1'b1;
        reg_write_s = 1'b1;
        done_s      = 1'b1;
      end
      StMemWrite: begin
        IorD        = 1'b1;
        mem_write_s = 1'b1;
        done_s      = 1'b1;
      end
      StExecute: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      StAluWb: begin
        RegDst      = 1'b1;
        reg_write_s = 1'b1;
        done_s      = 1'b1;
      end
      StBranch: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCSrc       = 2'b01;
        branch_s    = (op_q == OpBeq);
        branch_ne_s = ENABLE_BNE && (op_q == OpBne);
        done_s      = 1'b1;
      end
      StAddiExec: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StAddiWb: begin
        reg_write_s = 1'b1;
        done_s      = 1'b1;
      end
      StJump: begin
        PCSrc      = 2'b10;
        pc_write_s = 1'b1;
        done_s     = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset is asynchronous, so the enables must drop as soon as rst goes low
  assign PCWrite    = pc_write_s & rst;
  assign IRWrite    = ir_write_s & rst;
  assign MemWrite   = mem_write_s & rst;
  assign RegWrite   = reg_write_s & rst;
  assign Branch     = branch_s & rst;
  assign BranchNE   = branch_ne_s & rst;
  assign instr_done = done_s & rst;
  assign illegal_op = illegal_q;
  assign state      = state_q;

endmodule

// File: tb/tb_mips_main_control.sv
// Self-checking bench for mips_main_control. It uses a table of per-instruction state
// sequences and a queue of expected per-cycle results, plus hand-written reset, op_q
// latch and bne-disabled sequences.
module tb_mips_main_control;

  typedef struct packed {
    logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       branch, branch_ne, pc_write, instr_done;
  } ctl_t;

  typedef struct {
    logic [5:0]  op;
    int          len;
    logic [23:0] seq;  // state codes, first state in the top nibble
    string       name;
  } vec_t;

  typedef struct {
    logic [3:0] st;
    ctl_t       ctl;
    logic       ill;
  } exp_t;

  logic clk = 1'b0, rst = 1'b0, rst0 = 1'b0;
  logic [5:0] opcode = 6'd0, opcode0 = 6'b000101;

  logic iord1, mw1, irw1, rd1, m2r1, rw1, asa1, br1, bne1, pcw1, done1, ill1;
  logic [1:0] asb1, aop1, pcs1;
  logic [3:0] st1;
  logic iord0, mw0, irw0, rd0, m2r0, rw0, asa0, br0, bne0, pcw0, done0, ill0;
  logic [1:0] asb0, aop0, pcs0;
  logic [3:0] st0;
  ctl_t act1, act0;

  int checks = 0, failures = 0;
  logic pend = 1'b0;
  exp_t sb[$];
  vec_t vecs[10];

  always #5 clk = ~clk;

  mips_main_control #(.ENABLE_BNE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .opcode(opcode), .IorD(iord1), .MemWrite(mw1), .IRWrite(irw1),
    .RegDst(rd1), .MemtoReg(m2r1), .RegWrite(rw1), .ALUSrcA(asa1), .ALUSrcB(asb1),
    .ALUOp(aop1), .PCSrc(pcs1), .Branch(br1), .BranchNE(bne1), .PCWrite(pcw1),
    .instr_done(done1), .illegal_op(ill1), .state(st1)
  );

  mips_main_control #(.ENABLE_BNE(1'b0)) dut0 (
    .clk(clk), .rst(rst0), .opcode(opcode0), .IorD(iord0), .MemWrite(mw0), .IRWrite(irw0),
    .RegDst(rd0), .MemtoReg(m2r0), .RegWrite(rw0), .ALUSrcA(asa0), .ALUSrcB(asb0),
    .ALUOp(aop0), .PCSrc(pcs0), .Branch(br0), .BranchNE(bne0), .PCWrite(pcw0),
    .instr_done(done0), .illegal_op(ill0), .state(st0)
  );

  assign act1 = {iord1, mw1, irw1, rd1, m2r1, rw1, asa1, asb1, aop1, pcs1, br1, bne1, pcw1, done1};
  assign act0 = {iord0, mw0, irw0, rd0, m2r0, rw0, asa0, asb0, aop0, pcs0, br0, bne0, pcw0, done0};

  // Reference control table, written from the state descriptions
  function automatic ctl_t exp_ctl(input logic [3:0] st, input logic [5:0] op);
    ctl_t c = '0;
    case (st)
      4'd0:  begin c.alu_src_b = 2'b01; c.ir_write = 1'b1; c.pc_write = 1'b1; end
      4'd1:  c.alu_src_b = 2'b11;
      4'd2:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      4'd3:  c.iord = 1'b1;
      4'd4:  begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1; end
      4'd5:  begin c.iord = 1'b1; c.mem_write = 1'b1; c.instr_done = 1'b1; end
      4'd6:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      4'd7:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1; end
      4'd8:  begin
        c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.instr_done = 1'b1;
        c.branch = (op == 6'b000100); c.branch_ne = (op == 6'b000101);
      end
      4'd9:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      4'd10: begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
      4'd11: begin c.pc_src = 2'b10; c.pc_write = 1'b1; c.instr_done = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts just after a rising edge with the DUT in FETCH; returns the same way
  task automatic run_vec(input vec_t v);
    exp_t e;
    opcode = v.op;
    for (int i = 0; i < v.len; i++) begin
      e.st  = v.seq[23 - 4*i -: 4];
      e.ctl = exp_ctl(e.st, v.op);
      e.ill = (i == 0) ? pend : 1'b0;
      sb.push_back(e);
    end
    pend = (v.len == 2);
    for (int i = 0; i < v.len; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        check($sformatf("%s scoreboard empty", v.name), 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check($sformatf("%s c%0d state", v.name, i), 32'(st1), 32'(e.st));
        check($sformatf("%s c%0d ctl", v.name, i), 32'(act1), 32'(e.ctl));
        check($sformatf("%s c%0d illegal_op", v.name, i), 32'(ill1), 32'(e.ill));
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vecs[0] = '{6'b100011, 5, 24'h012340, "lw"};
    vecs[1] = '{6'b000000, 4, 24'h016700, "rtype"};
    vecs[2] = '{6'b000100, 3, 24'h018000, "beq"};
    vecs[3] = '{6'b000101, 3, 24'h018000, "bne"};
    vecs[4] = '{6'b111111, 2, 24'h010000, "ill3f"};
    vecs[5] = '{6'b101011, 4, 24'h012500, "sw"};
    vecs[6] = '{6'b001000, 4, 24'h019A00, "addi"};
    vecs[7] = '{6'b001100, 2, 24'h010000, "ill0c"};
    vecs[8] = '{6'b000010, 3, 24'h01B000, "j"};
    vecs[9] = '{6'b100011, 5, 24'h012340, "lw2"};

    // Reset state, checked before any clock edge
    #2;
    check("rst state", 32'(st1), 32'd0);
    check("rst enables", 32'({pcw1, irw1, mw1, rw1, br1, bne1, done1}), 32'd0);
    check("rst alusrcb", 32'(asb1), 32'b01);
    check("rst illegal_op", 32'(ill1), 32'd0);
    #5 rst = 1'b1; rst0 = 1'b1;

    for (int v = 0; v < 10; v++) run_vec(vecs[v]);

    // op_q latch: a change to the live opcode during BRANCH must not affect BranchNE
    opcode = 6'b000101;
    @(posedge clk); #1;
    @(posedge clk); #1;
    opcode = 6'b000100;
    @(negedge clk);
    check("latch state", 32'(st1), 32'd8);
    check("latch branch_ne", 32'(bne1), 32'd1);
    check("latch branch", 32'(br1), 32'd0);
    check("latch alu_op", 32'(aop1), 32'b01);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of EXECUTE
    opcode = 6'b000000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre-rst state", 32'(st1), 32'd6);
    #2 rst = 1'b0;
    #1;
    check("async rst state", 32'(st1), 32'd0);
    check("async rst enables", 32'({pcw1, irw1, rw1}), 32'd0);
    @(posedge clk); #1;
    check("held rst state", 32'(st1), 32'd0);
    check("held rst enables", 32'({pcw1, irw1, rw1, mw1, done1}), 32'd0);
    rst = 1'b1;
    #1;
    check("release ctl", 32'(act1), 32'(exp_ctl(4'd0, 6'd0)));
    pend = 1'b0;
    run_vec(vecs[8]);

    // With bne disabled, 000101 is handled like any other illegal opcode
    rst0 = 1'b0;
    #1;
    check("dut0 rst state", 32'(st0), 32'd0);
    rst0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("dut0 c%0d state", i), 32'(st0), 32'(i % 2));
      check($sformatf("dut0 c%0d ctl", i), 32'(act0), 32'(exp_ctl(4'(i % 2), 6'b000101)));
      check($sformatf("dut0 c%0d illegal_op", i), 32'(ill0), 32'(i == 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
